// File: rtl/ni_target_response_router_pkg.sv
// Shared types and constants for the target-side NI response router.
// Holds the default geometry, the header FSM state type and the return route
// table entries (same 7-bit path / 4-bit node encoding as the initiator-side LUT).
package ni_target_response_router_pkg;

    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned TID_W_DEF  = 4;
    localparam int unsigned PATH_W_DEF = 7;
    localparam int unsigned NODE_W_DEF = 4;

    // Return route table for this topology: first hop in LSBs, last hop in MSBs.
    localparam logic [6:0] ROUTE_PATH_ID0 = 7'b0000000;
    localparam logic [6:0] ROUTE_PATH_ID1 = 7'b0000001;
    localparam logic [6:0] ROUTE_PATH_ID2 = 7'b0000010;
    localparam logic [6:0] ROUTE_PATH_ID3 = 7'b0000011;

    typedef enum logic {
        HDR_EMPTY = 1'b0,
        HDR_FULL  = 1'b1
    } hdr_state_e;

endpackage

// File: rtl/ni_target_response_router_if.sv
// Bus bundle between the NI depacketizer / target core / packetizer and the router.
// slave : router side (consumes req/rsp, produces hdr and status)
// master: environment side
interface ni_target_response_router_if
    import ni_target_response_router_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TID_W  = TID_W_DEF,
    parameter int unsigned PATH_W = PATH_W_DEF,
    parameter int unsigned NODE_W = NODE_W_DEF
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [NODE_W-1:0] req_src_id;
    logic [TID_W-1:0]  req_tid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic              hdr_valid;
    logic              hdr_ready;
    logic [PATH_W-1:0] hdr_path;
    logic [NODE_W-1:0] hdr_dst_id;
    logic [TID_W-1:0]  hdr_tid;
    logic              hdr_err;
    logic [CNT_W-1:0]  outstanding;
    logic              decode_err;

    modport slave (
        input  req_valid, req_src_id, req_tid, rsp_valid, rsp_err, hdr_ready,
        output req_ready, rsp_ready, hdr_valid, hdr_path, hdr_dst_id, hdr_tid,
               hdr_err, outstanding, decode_err
    );

    modport master (
        output req_valid, req_src_id, req_tid, rsp_valid, rsp_err, hdr_ready,
        input  req_ready, rsp_ready, hdr_valid, hdr_path, hdr_dst_id, hdr_tid,
               hdr_err, outstanding, decode_err
    );

endinterface

// File: rtl/ni_target_response_router_lut.sv
// Combinational source-ID -> return-path lookup (routing_target_response_lut).
// Ports: src_id in; path_c out (route, zero on miss); failed_decoding_c out (ID not in table).
module ni_target_response_router_lut
    import ni_target_response_router_pkg::*;
#(
    parameter int unsigned PATH_W = PATH_W_DEF,
    parameter int unsigned NODE_W = NODE_W_DEF
) (
    input  logic [NODE_W-1:0] src_id,
    output logic [PATH_W-1:0] path_c,
    output logic              failed_decoding_c
);

    always_comb begin
        path_c            = '0;
        failed_decoding_c = 1'b1;
        case (src_id)
            NODE_W'(0): begin path_c = PATH_W'(ROUTE_PATH_ID0); failed_decoding_c = 1'b0; end
            NODE_W'(1): begin path_c = PATH_W'(ROUTE_PATH_ID1); failed_decoding_c = 1'b0; end
            NODE_W'(2): begin path_c = PATH_W'(ROUTE_PATH_ID2); failed_decoding_c = 1'b0; end
            NODE_W'(3): begin path_c = PATH_W'(ROUTE_PATH_ID3); failed_decoding_c = 1'b0; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/ni_target_response_router.sv
// Target-side NI response router: records (src_id, tid) of each accepted request
// in an in-order FIFO, and on each target response pops the oldest entry, maps
// the source ID to a return path and presents a registered header to the packetizer.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the request,
// response and header handshakes plus outstanding occupancy and decode_err pulse.
module ni_target_response_router
    import ni_target_response_router_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TID_W  = TID_W_DEF,
    parameter int unsigned PATH_W = PATH_W_DEF,
    parameter int unsigned NODE_W = NODE_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ni_target_response_router_if.slave    bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [NODE_W-1:0] src_mem_q [DEPTH];
    logic [TID_W-1:0]  tid_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    hdr_state_e        state_q, state_d;
    logic [PATH_W-1:0] hdr_path_q, hdr_path_d;
    logic [NODE_W-1:0] hdr_dst_id_q, hdr_dst_id_d;
    logic [TID_W-1:0]  hdr_tid_q, hdr_tid_d;
    logic              hdr_err_q, hdr_err_d;
    logic              decode_err_q, decode_err_d;

    logic              req_ready_c, rsp_ready_c, push_c, pop_c;
    logic [PATH_W-1:0] head_path_c;
    logic              head_miss_c;

    // Handshakes: a response may only pop when the header slot is free or draining.
    assign req_ready_c = (cnt_q != CNT_W'(DEPTH));
    assign rsp_ready_c = (cnt_q != '0) && ((state_q == HDR_EMPTY) || bus.hdr_ready);
    assign push_c      = bus.req_valid && req_ready_c;
    assign pop_c       = bus.rsp_valid && rsp_ready_c;

    // Route lookup on the FIFO head.
    ni_target_response_router_lut #(
        .PATH_W (PATH_W),
        .NODE_W (NODE_W)
    ) u_lut (
        .src_id            (src_mem_q[rd_ptr_q]),
        .path_c            (head_path_c),
        .failed_decoding_c (head_miss_c)
    );

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            src_mem_q[wr_ptr_q] <= bus.req_src_id;
            tid_mem_q[wr_ptr_q] <= bus.req_tid;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Header FSM: a decode miss drops the entry without touching the header register.
    always_comb begin
        state_d      = state_q;
        hdr_path_d   = hdr_path_q;
        hdr_dst_id_d = hdr_dst_id_q;
        hdr_tid_d    = hdr_tid_q;
        hdr_err_d    = hdr_err_q;
        decode_err_d = pop_c && head_miss_c;

        case (state_q)
            HDR_EMPTY: if (pop_c && !head_miss_c) state_d = HDR_FULL;
            HDR_FULL: begin
                if (bus.hdr_ready) begin
                    state_d = (pop_c && !head_miss_c) ? HDR_FULL : HDR_EMPTY;
                end
            end
            default: state_d = HDR_EMPTY;
        endcase

        if (pop_c && !head_miss_c) begin
            hdr_path_d   = head_path_c;
            hdr_dst_id_d = src_mem_q[rd_ptr_q];
            hdr_tid_d    = tid_mem_q[rd_ptr_q];
            hdr_err_d    = bus.rsp_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            state_q      <= HDR_EMPTY;
            hdr_path_q   <= '0;
            hdr_dst_id_q <= '0;
            hdr_tid_q    <= '0;
            hdr_err_q    <= 1'b0;
            decode_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            hdr_path_q   <= hdr_path_d;
            hdr_dst_id_q <= hdr_dst_id_d;
            hdr_tid_q    <= hdr_tid_d;
            hdr_err_q    <= hdr_err_d;
            decode_err_q <= decode_err_d;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_ready   = rsp_ready_c;
    assign bus.hdr_valid   = (state_q == HDR_FULL);
    assign bus.hdr_path    = hdr_path_q;
    assign bus.hdr_dst_id  = hdr_dst_id_q;
    assign bus.hdr_tid     = hdr_tid_q;
    assign bus.hdr_err     = hdr_err_q;
    assign bus.outstanding = cnt_q;
    assign bus.decode_err  = decode_err_q;

endmodule

// File: tb/tb_ni_target_response_router.sv
// Bench for ni_target_response_router: reference FIFO + header scoreboard,
// updated from observed handshakes and compared every cycle on the falling edge.
module tb_ni_target_response_router;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ni_target_response_router_if bus ();

    ni_target_response_router dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] tid;
    } req_t;

    typedef struct packed {
        logic [6:0] path;
        logic [3:0] dst;
        logic [3:0] tid;
        logic       err;
    } hdr_t;

    req_t ref_q [$];
    hdr_t exp_q [$];
    bit   derr_pend = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Return route table: {miss, path}
    function automatic logic [7:0] ref_route(input logic [3:0] id);
        case (id)
            4'h0:    return {1'b0, 7'b0000000};
            4'h1:    return {1'b0, 7'b0000001};
            4'h2:    return {1'b0, 7'b0000010};
            4'h3:    return {1'b0, 7'b0000011};
            default: return {1'b1, 7'b0000000};
        endcase
    endfunction

    // Monitor / scoreboard
    req_t        mon_r;
    hdr_t        mon_h;
    logic [7:0]  mon_rt;
    always @(negedge clk) begin
        if (!rst_n) begin
            ref_q.delete();
            exp_q.delete();
            derr_pend = 1'b0;
        end else begin
            check_eq("req_ready", 32'(bus.req_ready), 32'(ref_q.size() != 4));
            check_eq("rsp_ready", 32'(bus.rsp_ready),
                     32'((ref_q.size() != 0) && ((exp_q.size() == 0) || bus.hdr_ready)));
            check_eq("outstanding", 32'(bus.outstanding), 32'(ref_q.size()));
            check_eq("hdr_valid", 32'(bus.hdr_valid), 32'(exp_q.size() != 0));
            check_eq("decode_err", 32'(bus.decode_err), 32'(derr_pend));
            if (bus.hdr_valid && exp_q.size() != 0) begin
                mon_h = exp_q[0];
                check_eq("hdr_path", 32'(bus.hdr_path), 32'(mon_h.path));
                check_eq("hdr_dst_id", 32'(bus.hdr_dst_id), 32'(mon_h.dst));
                check_eq("hdr_tid", 32'(bus.hdr_tid), 32'(mon_h.tid));
                check_eq("hdr_err", 32'(bus.hdr_err), 32'(mon_h.err));
                if (bus.hdr_ready) void'(exp_q.pop_front());
            end
            derr_pend = 1'b0;
            if (bus.rsp_valid && bus.rsp_ready && ref_q.size() != 0) begin
                mon_r  = ref_q.pop_front();
                mon_rt = ref_route(mon_r.src);
                if (mon_rt[7]) derr_pend = 1'b1;
                else exp_q.push_back('{path: mon_rt[6:0], dst: mon_r.src, tid: mon_r.tid, err: bus.rsp_err});
            end
            if (bus.req_valid && bus.req_ready)
                ref_q.push_back('{src: bus.req_src_id, tid: bus.req_tid});
        end
    end

    task automatic send_req(input logic [3:0] src, input logic [3:0] tid);
        bit ok = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_src_id = src;
        bus.req_tid    = tid;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1'b1; break; end
        end
        check_eq("req_accept", 32'(ok), 32'd1);
        if (ok) begin @(posedge clk); #1; end
        bus.req_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic err);
        bit ok = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rsp_ready) begin ok = 1'b1; break; end
        end
        check_eq("rsp_accept", 32'(ok), 32'd1);
        if (ok) begin @(posedge clk); #1; end
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [3:0] wrap_src [10];

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_src_id = '0;
        bus.req_tid    = '0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_err    = 1'b0;
        bus.hdr_ready  = 1'b1;
        wrap_src[0] = 4'h2; wrap_src[1] = 4'h9; wrap_src[2] = 4'h0; wrap_src[3] = 4'h3;
        wrap_src[4] = 4'h1; wrap_src[5] = 4'hF; wrap_src[6] = 4'h2; wrap_src[7] = 4'h4;
        wrap_src[8] = 4'h3; wrap_src[9] = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset with entries and a pending header
        bus.hdr_ready = 1'b0;
        send_req(4'h1, 4'h1);
        send_req(4'h2, 4'h2);
        send_rsp(1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_outstanding", 32'(bus.outstanding), 32'd0);
        check_eq("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_rsp_ready", 32'(bus.rsp_ready), 32'd0);
        check_eq("rst_hdr_path", 32'(bus.hdr_path), 32'd0);
        check_eq("rst_hdr_tid", 32'(bus.hdr_tid), 32'd0);
        check_eq("rst_decode_err", 32'(bus.decode_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.hdr_ready = 1'b1;

        // Single transaction
        send_req(4'h2, 4'h5);
        send_rsp(1'b0);
        @(negedge clk);
        check_eq("single_hdr_valid", 32'(bus.hdr_valid), 32'd1);
        check_eq("single_path", 32'(bus.hdr_path), 32'h02);
        check_eq("single_dst", 32'(bus.hdr_dst_id), 32'h2);
        check_eq("single_tid", 32'(bus.hdr_tid), 32'h5);
        @(posedge clk); #1;

        // Full FIFO, 5th request held until a pop
        for (int i = 0; i < 4; i++) send_req(4'(i), 4'(i + 8));
        @(negedge clk);
        check_eq("full_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        fork
            send_req(4'h3, 4'h7);
            begin repeat (3) @(posedge clk); #1; send_rsp(1'b0); end
        join
        @(negedge clk);
        check_eq("full_refill", 32'(bus.outstanding), 32'd4);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_rsp(1'b0);

        // Header backpressure, then back-to-back headers
        send_req(4'h0, 4'h1);
        send_req(4'h1, 4'h2);
        send_req(4'h3, 4'h3);
        bus.hdr_ready = 1'b0;
        fork
            begin send_rsp(1'b1); send_rsp(1'b0); send_rsp(1'b0); end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check_eq("bp_rsp_ready", 32'(bus.rsp_ready), 32'd0);
                end
                @(posedge clk); #1 bus.hdr_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk); #1;

        // Decode miss
        send_req(4'h9, 4'hA);
        send_rsp(1'b0);
        @(negedge clk);
        check_eq("miss_decode_err", 32'(bus.decode_err), 32'd1);
        check_eq("miss_hdr_valid", 32'(bus.hdr_valid), 32'd0);
        check_eq("miss_outstanding", 32'(bus.outstanding), 32'd0);
        @(negedge clk);
        check_eq("miss_pulse_end", 32'(bus.decode_err), 32'd0);
        @(posedge clk); #1;

        // Simultaneous push/pop at occupancy 2
        send_req(4'h1, 4'h3);
        send_req(4'h2, 4'h4);
        fork
            send_req(4'h0, 4'h6);
            send_rsp(1'b0);
        join
        @(negedge clk);
        check_eq("pushpop_occ", 32'(bus.outstanding), 32'd2);
        @(posedge clk); #1;
        send_rsp(1'b0);
        send_rsp(1'b0);

        // Wrap: mixed sources incl. misses, random header backpressure
        fork
            for (int i = 0; i < 10; i++) send_req(wrap_src[i], 4'(i));
            for (int i = 0; i < 10; i++) send_rsp(1'($urandom_range(0, 1)));
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk); #1 bus.hdr_ready = 1'($urandom_range(0, 1));
                end
                bus.hdr_ready = 1'b1;
            end
        join
        bus.hdr_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("scb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("ref_drained", 32'(ref_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
